pool_scan_ctrl: RTL and testbench
=================================

# pool_scan_ctrl

Frame sequencer for the streaming 2x2 pooling stage. It accepts the convolution layer's pixel stream, tags every pixel with raster x/y coordinates, and forwards pixel plus coordinates to the pooling datapath one cycle later. It counts the pooled results that come back and signals frame completion. It sits between the conv engine output and the pooling block, under control of the layer scheduler (start/done).

## Interface
- IMG_W, 64, frame width in pixels (2..1023)
- IMG_H, 64, frame height in pixels (2..1023)
- CW, 10, coordinate width
- DW, 12, signed pixel width
- TIMEOUT, 255, drain watchdog limit in cycles (used only with macro)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle frame start request
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse at frame completion
- overrun  out  1  sticky; pixel arrived while IDLE; cleared by start
- timeout_err  out  1  sticky drain-timeout flag; cleared by start (tied 0 without macro)
- pix_valid_in  in  1  conv pixel strobe
- pix_data_in  in  DW  signed conv pixel
- pool_valid  out  1  to pooling valid input
- pool_data  out  DW  to pooling data input
- pool_x  out  CW  x coordinate of pool_data
- pool_y  out  CW  y coordinate of pool_data
- mp_valid_out  in  1  pooled-result strobe returned from pooling block

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start -> RUN; x=0, y=0, out_cnt=0, sticky flags cleared. Pixels arriving in IDLE are dropped and set overrun.
- RUN: each pix_valid_in registers data, x, y onto pool_*. x increments and wraps at IMG_W-1 to 0 with y+1. Last pixel (IMG_W-1, IMG_H-1) -> DRAIN, or -> DONE if out_cnt already equals EXP.
- EXP = ceil(IMG_W/2)*ceil(IMG_H/2); out_cnt increments on every mp_valid_out in RUN or DRAIN and saturates at EXP.
- DRAIN: input pixels are dropped and set overrun. When out_cnt reaches EXP, counting any mp_valid_out in the current cycle -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- mp_valid_out in IDLE/DONE is ignored.

## Timing
- Reset values: busy=0, done=0, overrun=0, timeout_err=0, pool_valid=0, pool_data=0, pool_x=0, pool_y=0; state=IDLE; counters 0.
- Reset mid-frame aborts immediately; no done is issued.
- pool_valid/pool_data/pool_x/pool_y are registered with 1-cycle latency from pix_valid_in. pool_valid=0 in cycles without an accepted pixel. pool_data holds its last value.
- busy is registered: it rises the cycle after start and falls together with done going low.
- Full back-to-back input at one pixel per cycle is supported; there is no backpressure.

## Configuration
- POOL_SCAN_TIMEOUT_EN defined: a cycle counter runs in DRAIN and resets on every mp_valid_out. On reaching TIMEOUT, set timeout_err and go to DONE (done still pulses).
- POOL_SCAN_TIMEOUT_EN undefined: no counter; DRAIN waits indefinitely; timeout_err is tied to 0.

## Structure
- Shared package pool_pkg holds the state enum (IDLE/RUN/DRAIN/DONE), CW/DW defaults, and the EXP computation function.
- One sub-module, pool_coord_cnt: x/y raster counter with wrap and last-pixel flag, parameterised by IMG_W/IMG_H.

## Test plan
- IMG_W=IMG_H=4, start, 16 back-to-back pixels, model pool returning 4 mp_valid_out -> pool_x/pool_y sequence 0..3 per row, y 0..3; last pixel lands in DRAIN; done one cycle after 4th result; busy spans start+1..done.
- IMG_W=IMG_H=3, all 4 results returned before the last pixel (2,2) -> RUN goes directly to DONE; EXP=4.
- Pixel strobes with 0-3 cycle random gaps -> coordinates advance only on valid; pool_valid mirrors input delayed by exactly 1 cycle.
- Pixel while IDLE -> overrun=1, no pool_valid; next start clears overrun.
- rst asserted mid-RUN at pixel 7 -> all outputs 0 within the same cycle; a new start restarts at x=0,y=0.
- With POOL_SCAN_TIMEOUT_EN and TIMEOUT=10, withhold the last result -> timeout_err=1 and done pulse 10 cycles into DRAIN.

Source files
------------

// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Shared types and helpers for the 2x2 pooling frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    localparam int CW_DEFAULT = 10;
    localparam int DW_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of pooled results a w x h frame produces (odd edges still pool).
    function automatic int exp_count(input int w, input int h);
        return ((w + 1) / 2) * ((h + 1) / 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_coord_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pool_coord_cnt
//  Description : Raster x/y counter with row wrap and last-pixel flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_coord_cnt #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_last
);

    localparam logic [CW-1:0] c_xmax = CW'(IMG_W - 1);
    localparam logic [CW-1:0] c_ymax = CW'(IMG_H - 1);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          w_xend;

    assign w_xend = (r_x == c_xmax);
    assign o_last = w_xend && (r_y == c_ymax);
    assign o_x    = r_x;
    assign o_y    = r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_xend) begin
                r_x <= '0;
                r_y <= o_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pool_scan_ctrl
//  Description : Frame sequencer tagging conv pixels with raster coordinates
//                and counting pooled results. POOL_SCAN_TIMEOUT_EN enables a
//                drain watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_scan_ctrl
    import pool_pkg::*;
#(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int CW      = CW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 pix_valid_in,
    input  logic signed [DW-1:0] pix_data_in,
    output logic                 pool_valid,
    output logic signed [DW-1:0] pool_data,
    output logic        [CW-1:0] pool_x,
    output logic        [CW-1:0] pool_y,
    input  logic                 mp_valid_out
);

    localparam int               c_exp   = exp_count(IMG_W, IMG_H);
    localparam int               c_ocw   = $clog2(c_exp + 1);
    localparam logic [c_ocw-1:0] c_exp_v = c_ocw'(c_exp);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overrun;
    logic                  r_pool_valid;
    logic signed [DW-1:0]  r_pool_data;
    logic [CW-1:0]         r_pool_x;
    logic [CW-1:0]         r_pool_y;
    logic [c_ocw-1:0]      r_out_cnt;
    logic [c_ocw-1:0]      w_cnt_next;
    logic [CW-1:0]         w_x;
    logic [CW-1:0]         w_y;
    logic                  w_last;
    logic                  w_clr;
    logic                  w_adv;

    assign w_clr      = (r_state == ST_IDLE) && start;
    assign w_adv      = (r_state == ST_RUN) && pix_valid_in;
    assign w_cnt_next = (mp_valid_out && (r_out_cnt != c_exp_v)) ? r_out_cnt + 1'b1 : r_out_cnt;

    pool_coord_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_coord (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_adv  (w_adv),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_last)
    );

`ifdef POOL_SCAN_TIMEOUT_EN
    localparam int            c_tw      = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_to_last = c_tw'(TIMEOUT - 1);
    logic [c_tw-1:0] r_tcnt;
    logic            r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    // TIMEOUT has no effect in this build; the flag is constant low.
    assign timeout_err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
            r_pool_x     <= '0;
            r_pool_y     <= '0;
            r_out_cnt    <= '0;
`ifdef POOL_SCAN_TIMEOUT_EN
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_pool_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_out_cnt <= '0;
                        r_overrun <= 1'b0;
`ifdef POOL_SCAN_TIMEOUT_EN
                        r_tcnt        <= '0;
                        r_timeout_err <= 1'b0;
`endif
                    end else if (pix_valid_in) begin
                        r_overrun <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_out_cnt <= w_cnt_next;
                    if (pix_valid_in) begin
                        r_pool_valid <= 1'b1;
                        r_pool_data  <= pix_data_in;
                        r_pool_x     <= w_x;
                        r_pool_y     <= w_y;
                        if (w_last) begin
                            if (r_out_cnt == c_exp_v) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    r_out_cnt <= w_cnt_next;
                    if (pix_valid_in) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_cnt_next == c_exp_v) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
`ifdef POOL_SCAN_TIMEOUT_EN
                    end else if (mp_valid_out) begin
                        r_tcnt <= '0;
                    end else if (r_tcnt == c_to_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_DONE;
                        r_done        <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;
    assign pool_valid = r_pool_valid;
    assign pool_data  = r_pool_data;
    assign pool_x     = r_pool_x;
    assign pool_y     = r_pool_y;

endmodule
`default_nettype wire

// File: tb/tb_pool_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_scan_ctrl
//  Description : Randomized self-checking bench for pool_scan_ctrl (4x4 frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_scan_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int N   = W * H;
    localparam int EXP = ((W + 1) / 2) * ((H + 1) / 2);
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, overrun, timeout_err;
    logic        pix_valid_in;
    logic [11:0] pix_data_in;
    logic        pool_valid;
    logic [11:0] pool_data;
    logic [9:0]  pool_x, pool_y;
    logic        mp_valid_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: frame progress expressed as pixel index and result count.
    int m_busy, m_done, m_idx, m_res, m_ovr, m_terr, m_tcnt;
    int e_pv, e_pd, e_px, e_py;

    pool_scan_ctrl #(
        .IMG_W   (W),
        .IMG_H   (H),
        .CW      (10),
        .DW      (12),
        .TIMEOUT (TO)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .pix_valid_in (pix_valid_in),
        .pix_data_in  (pix_data_in),
        .pool_valid   (pool_valid),
        .pool_data    (pool_data),
        .pool_x       (pool_x),
        .pool_y       (pool_y),
        .mp_valid_out (mp_valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_idx = 0; m_res = 0;
        m_ovr = 0; m_terr = 0; m_tcnt = 0;
        e_pv = 0; e_pd = 0; e_px = 0; e_py = 0;
    endtask

    task automatic model_update(input bit st, input bit pv, input logic [11:0] pd, input bit mp);
        int res_old;
        e_pv = 0;
        if (m_done != 0) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy == 0) begin
            if (pv) m_ovr = 1;
            if (st) begin
                m_busy = 1; m_idx = 0; m_res = 0; m_ovr = 0; m_terr = 0; m_tcnt = 0;
            end
        end else begin
            res_old = m_res;
            if (mp && m_res < EXP) m_res++;
            if (m_idx < N) begin
                if (pv) begin
                    e_pv = 1; e_pd = int'(pd); e_px = m_idx % W; e_py = m_idx / W;
                    m_idx++;
                    if (m_idx == N) begin
                        if (res_old == EXP) m_done = 1;
                        m_tcnt = 0;
                    end
                end
            end else begin
                if (pv) m_ovr = 1;
                if (m_res == EXP) m_done = 1;
`ifdef POOL_SCAN_TIMEOUT_EN
                else if (mp) m_tcnt = 0;
                else begin
                    m_tcnt++;
                    if (m_tcnt == TO) begin
                        m_terr = 1;
                        m_done = 1;
                    end
                end
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},        int'(busy),        m_busy);
        chk({tag, ".done"},        int'(done),        m_done);
        chk({tag, ".overrun"},     int'(overrun),     m_ovr);
        chk({tag, ".timeout_err"}, int'(timeout_err), m_terr);
        chk({tag, ".pool_valid"},  int'(pool_valid),  e_pv);
        chk({tag, ".pool_data"},   int'(pool_data),   e_pd);
        chk({tag, ".pool_x"},      int'(pool_x),      e_px);
        chk({tag, ".pool_y"},      int'(pool_y),      e_py);
    endtask

    task automatic step(input string tag, input bit st, input bit pv, input logic [11:0] pd, input bit mp);
        start = st; pix_valid_in = pv; pix_data_in = pd; mp_valid_out = mp;
        @(posedge clk);
        model_update(st, pv, pd, mp);
        #1;
        check_all(tag);
    endtask

    task automatic run_out(input string tag, input int mp_period);
        int cyc;
        cyc = 0;
        while (m_busy != 0 && cyc < 200) begin
            step(tag, 1'b0, 1'b0, 12'd0, (cyc % mp_period) == (mp_period - 1));
            cyc++;
        end
        if (m_busy != 0) chk({tag, ".bound"}, 0, 1);
    endtask

    initial begin
        int gap, n, cyc;
        bit pv, mp, st;

        rst = 1'b1; start = 1'b0; pix_valid_in = 1'b0; pix_data_in = '0; mp_valid_out = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;

        // Full frame back to back; three results during RUN, last one in DRAIN.
        step("f4_start", 1'b1, 1'b0, 12'd0, 1'b0);
        for (int i = 0; i < N; i++)
            step("f4_pix", 1'b0, 1'b1, 12'(100 + i * 37), (i == 5) || (i == 9) || (i == 13));
        step("f4_drain", 1'b0, 1'b0, 12'd0, 1'b0);
        run_out("f4_drain", 2);

        // All results returned before the final pixel: RUN straight to DONE.
        step("direct_start", 1'b1, 1'b0, 12'd0, 1'b0);
        for (int i = 0; i < N; i++)
            step("direct_pix", 1'b0, 1'b1, 12'(4000 - i), (i % 3 == 0) && (i < 12));
        run_out("direct_done", 1);

        // Pixels while idle set overrun and produce nothing; start clears it.
        step("idle_pix", 1'b0, 1'b1, 12'hABC, 1'b1);
        step("idle_pix", 1'b0, 1'b1, 12'h123, 1'b0);
        step("idle_clear", 1'b1, 1'b0, 12'd0, 1'b0);
        for (int i = 0; i < N; i++)
            step("ovr_pix", 1'b0, 1'b1, 12'(i), 1'b0);
        step("ovr_drain", 1'b0, 1'b1, 12'd7, 1'b1);
        run_out("ovr_drain", 3);

        // Randomized frames with 0-3 cycle gaps, random results and stray starts.
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++)
                step("rnd_idle", 1'b0, 1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));
            step("rnd_start", 1'b1, 1'b0, 12'd0, 1'b0);
            gap = 0; cyc = 0;
            while (m_busy != 0 && cyc < 400) begin
                if (gap > 0) begin
                    pv = 1'b0; gap--;
                end else begin
                    pv = 1'b1; gap = $urandom_range(0, 3);
                end
                mp = ($urandom_range(0, 2) == 0);
                st = ($urandom_range(0, 15) == 0);
                step("rnd", st, pv, 12'($urandom), mp);
                cyc++;
            end
            if (m_busy != 0) chk("rnd.bound", 0, 1);
        end

        // Asynchronous reset in the middle of a frame, at pixel 7.
        step("rst_start", 1'b1, 1'b0, 12'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            step("rst_pix", 1'b0, 1'b1, 12'(i + 1), 1'($urandom_range(0, 1)));
        start = 1'b0; pix_valid_in = 1'b1; pix_data_in = 12'd777; mp_valid_out = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        pix_valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step("rst_restart", 1'b1, 1'b0, 12'd0, 1'b0);
        step("rst_pix0", 1'b0, 1'b1, 12'd55, 1'b0);
        chk("rst_pix0.x0", int'(pool_x), 0);
        chk("rst_pix0.y0", int'(pool_y), 0);
        for (int i = 1; i < N; i++)
            step("rst_refill", 1'b0, 1'b1, 12'($urandom), 1'b0);

`ifdef POOL_SCAN_TIMEOUT_EN
        // Withhold the last result so the drain watchdog fires.
        for (int i = 0; i < EXP - 1; i++)
            step("to_res", 1'b0, 1'b0, 12'd0, 1'b1);
        run_out("to_wait", 1000);
        chk("to.flag_held", int'(timeout_err), 1);
`else
        run_out("tail", 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
